// File: rtl/sine_pkg.sv
// Shared defaults for the DDS sine ROM reader.
package sine_pkg;

    localparam int unsigned PHASE_W   = 32;
    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned ROM_LAT   = 2;
    localparam int unsigned DIV_W     = 16;
    localparam int unsigned MID_SCALE = 2 ** (DATA_W - 1);

endpackage

// File: rtl/sine_prescaler.sv
// Sample-rate prescaler: counts 0..div while enabled and flags the terminal cycle.
module sine_prescaler
    import sine_pkg::*;
#(
    parameter int unsigned DIV_W = sine_pkg::DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick_c
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_hit;

    assign w_hit    = (r_cnt == i_div);
    // A clear steals the tick so no address or sample is produced that cycle.
    assign o_tick_c = i_en & ~i_clr & w_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_en || i_clr || w_hit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/sine_rom_reader.sv
// DDS phase accumulator driving the sine ROM address and returning timed samples.
// Optional amplitude scaling stage enabled by SINE_AMP_SCALE_EN.
module sine_rom_reader
    import sine_pkg::*;
#(
    parameter int unsigned PHASE_W = sine_pkg::PHASE_W,
    parameter int unsigned ADDR_W  = sine_pkg::ADDR_W,
    parameter int unsigned DATA_W  = sine_pkg::DATA_W,
    parameter int unsigned ROM_LAT = sine_pkg::ROM_LAT,
    parameter int unsigned DIV_W   = sine_pkg::DIV_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               phase_clr,
    input  logic [PHASE_W-1:0] ftw,
    input  logic               ftw_load,
    input  logic [ADDR_W-1:0]  phase_ofs,
    input  logic [DIV_W-1:0]   div,
`ifdef SINE_AMP_SCALE_EN
    input  logic [DATA_W-1:0]  amp,
`endif
    input  logic [DATA_W-1:0]  rom_data,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic [DATA_W-1:0]  sample,
    output logic               sample_valid,
    output logic               wrap
);

`ifdef SINE_AMP_SCALE_EN
    localparam int unsigned VP_N = ROM_LAT + 2;
`else
    localparam int unsigned VP_N = ROM_LAT + 1;
`endif

    logic               w_tick;
    logic [PHASE_W:0]   w_sum;
    logic [ADDR_W-1:0]  w_addr;

    logic [PHASE_W-1:0] r_acc;
    logic [PHASE_W-1:0] r_ftw_act;
    logic [PHASE_W-1:0] r_ftw_pend;
    logic               r_pend_flag;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic               r_wrap;
    logic [VP_N-1:0]    r_vpipe;
    logic [DATA_W-1:0]  r_sample;
    logic               r_sample_valid;

    sine_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (en),
        .i_clr    (phase_clr),
        .i_div    (div),
        .o_tick_c (w_tick)
    );

    assign w_sum  = {1'b0, r_acc} + {1'b0, r_ftw_act};
    assign w_addr = r_acc[PHASE_W-1 -: ADDR_W] + phase_ofs;

    // Tuning word: direct load when idle, otherwise staged until the next tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ftw_act   <= '0;
            r_ftw_pend  <= '0;
            r_pend_flag <= 1'b0;
        end else if (ftw_load && !en) begin
            r_ftw_act   <= ftw;
            r_pend_flag <= 1'b0;
        end else begin
            if (w_tick && r_pend_flag) begin
                r_ftw_act <= r_ftw_pend;
            end
            if (ftw_load) begin
                r_ftw_pend  <= ftw;
                r_pend_flag <= 1'b1;
            end else if (w_tick) begin
                r_pend_flag <= 1'b0;
            end
        end
    end

    // Accumulator and address; the address uses the pre-add phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_rom_addr <= '0;
            r_wrap     <= 1'b0;
        end else begin
            r_wrap <= w_tick & w_sum[PHASE_W];
            if (phase_clr) begin
                r_acc <= '0;
            end else if (w_tick) begin
                r_acc      <= w_sum[PHASE_W-1:0];
                r_rom_addr <= w_addr;
            end
        end
    end

`ifdef SINE_AMP_SCALE_EN
    logic        [DATA_W-1:0]   r_raw;
    logic signed [DATA_W:0]     w_s;
    logic signed [2*DATA_W+1:0] w_prod;
    logic        [DATA_W-1:0]   w_scaled;

    assign w_s      = $signed({1'b0, r_raw}) - $signed((DATA_W + 1)'(MID_SCALE));
    assign w_prod   = w_s * $signed({1'b0, amp});
    assign w_scaled = DATA_W'(w_prod >>> DATA_W) + DATA_W'(MID_SCALE);
`endif

    // Valid pipe tracks ROM latency; sample captures data as its tick emerges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vpipe        <= '0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
`ifdef SINE_AMP_SCALE_EN
            r_raw          <= '0;
`endif
        end else begin
            r_vpipe        <= {r_vpipe[VP_N-2:0], w_tick};
            r_sample_valid <= r_vpipe[VP_N-1];
`ifdef SINE_AMP_SCALE_EN
            if (r_vpipe[ROM_LAT]) begin
                r_raw <= rom_data;
            end
            if (r_vpipe[ROM_LAT+1]) begin
                r_sample <= w_scaled;
            end
`else
            if (r_vpipe[ROM_LAT]) begin
                r_sample <= rom_data;
            end
`endif
        end
    end

    assign rom_addr     = r_rom_addr;
    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;
    assign wrap         = r_wrap;

endmodule

// File: tb/tb_sine_rom_reader.sv
// Scoreboard bench for sine_rom_reader with a 2-cycle ROM model.
module tb_sine_rom_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        phase_clr;
    logic [31:0] ftw;
    logic        ftw_load;
    logic [11:0] phase_ofs;
    logic [15:0] div;
    logic [7:0]  rom_data;
    logic [11:0] rom_addr;
    logic [7:0]  sample;
    logic        sample_valid;
    logic        wrap;
`ifdef SINE_AMP_SCALE_EN
    logic [7:0]  amp = 8'd128;
    localparam int VL = 5;
`else
    localparam int VL = 4;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] sb_q[$];
    logic [7:0] r_d1, r_d2;

    always #5 clk = ~clk;

    sine_rom_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .phase_clr    (phase_clr),
        .ftw          (ftw),
        .ftw_load     (ftw_load),
        .phase_ofs    (phase_ofs),
        .div          (div),
`ifdef SINE_AMP_SCALE_EN
        .amp          (amp),
`endif
        .rom_data     (rom_data),
        .rom_addr     (rom_addr),
        .sample       (sample),
        .sample_valid (sample_valid),
        .wrap         (wrap)
    );

    function automatic logic [7:0] rom_f(input logic [11:0] a);
        return a[7:0] ^ a[11:4];
    endfunction

    function automatic logic [7:0] exp_f(input logic [11:0] a);
`ifdef SINE_AMP_SCALE_EN
        int s;
        int p;
        s = int'(rom_f(a)) - 128;
        p = (s * int'(amp)) >>> 8;
        return 8'(p + 128);
`else
        return rom_f(a);
`endif
    endfunction

    // ROM with two cycles of clock-to-data latency
    always @(posedge clk) begin
        r_d1 <= rom_f(rom_addr);
        r_d2 <= r_d1;
    end
    assign rom_data = r_d2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && sample_valid) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid: got sample %0h expected no valid at %0t", sample, $time);
            end else begin
                chk("sample", 32'(sample), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic [31:0] f, input logic [15:0] d, input logic [11:0] o);
        en        = 1'b0;
        ftw       = f;
        ftw_load  = 1'b1;
        phase_clr = 1'b1;
        div       = d;
        phase_ofs = o;
        step(1);
        ftw_load  = 1'b0;
        phase_clr = 1'b0;
    endtask

    initial begin
        logic [11:0] a4 [4];
        rst_n = 1'b0; en = 1'b0; phase_clr = 1'b0; ftw = '0; ftw_load = 1'b0;
        phase_ofs = '0; div = '0;
        step(2);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_sample", 32'(sample), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        rst_n = 1'b1;
        step(1);

        // one address step per cycle, first valid VL cycles after first tick
        setup(32'h0010_0000, 16'd0, 12'd0);
        for (int i = 0; i < 8; i++) sb_q.push_back(exp_f(12'(i)));
        en = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            step(1);
            chk("t1_addr", 32'(rom_addr), 32'(j - 1));
            chk("t1_valid", 32'(sample_valid), 32'(j >= VL));
        end
        en = 1'b0;
        step(8);
        chk("t1_hold", 32'(sample), 32'(exp_f(12'd7)));

        // half-turn tuning word, div=3: alternating addresses, wrap every other tick
        setup(32'h8000_0000, 16'd3, 12'd0);
        for (int i = 0; i < 4; i++) sb_q.push_back(exp_f((i % 2 == 1) ? 12'd2048 : 12'd0));
        en = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            step(1);
            chk("t2_wrap", 32'(wrap), 32'(j == 8 || j == 16));
            chk("t2_valid", 32'(sample_valid), 32'(j == 3 + VL || j == 7 + VL || j == 11 + VL));
            if (j >= 4) chk("t2_addr", 32'(rom_addr), (((j - 4) / 4) % 2 == 1) ? 32'd2048 : 32'd0);
        end
        en = 1'b0;
        step(8);

        // zero tuning word with offset: constant address, valid every div+1
        setup(32'h0, 16'd2, 12'd1024);
        for (int i = 0; i < 4; i++) sb_q.push_back(exp_f(12'd1024));
        en = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            step(1);
            if (j >= 3) chk("t3_addr", 32'(rom_addr), 32'd1024);
            chk("t3_valid", 32'(sample_valid), 32'(j >= 2 + VL && (j - 2 - VL) % 3 == 0));
        end
        en = 1'b0;
        step(8);
        chk("t3_hold", 32'(sample), 32'(exp_f(12'd1024)));
        chk("t3_hold_valid", 32'(sample_valid), 32'd0);

        // mid-period retune: deltas 1,1,2
        setup(32'h0010_0000, 16'd3, 12'd0);
        a4[0] = 12'd0; a4[1] = 12'd1; a4[2] = 12'd2; a4[3] = 12'd4;
        for (int i = 0; i < 4; i++) sb_q.push_back(exp_f(a4[i]));
        en = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            step(1);
            if (j % 4 == 0) chk("t4_addr", 32'(rom_addr), 32'(a4[j / 4 - 1]));
            ftw_load = 1'b0;
            if (j == 5) begin
                ftw      = 32'h0020_0000;
                ftw_load = 1'b1;
            end
        end
        en = 1'b0;
        step(8);

        // phase_clr in a tick cycle: tick suppressed, address restarts at offset
        setup(32'h0010_0000, 16'd1, 12'd16);
        sb_q.push_back(exp_f(12'd16));
        sb_q.push_back(exp_f(12'd16));
        sb_q.push_back(exp_f(12'd17));
        en = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            step(1);
            phase_clr = 1'b0;
            if (j == 2 || j == 4 || j == 6) chk("t5_addr", 32'(rom_addr), 32'd16);
            if (j == 8) chk("t5_addr_last", 32'(rom_addr), 32'd17);
            if (j == 3 + VL) chk("t5_no_valid", 32'(sample_valid), 32'd0);
            if (j == 3) phase_clr = 1'b1;
        end
        en = 1'b0;
        step(10);

        // asynchronous reset mid-run drops in-flight samples
        setup(32'h0010_0000, 16'd0, 12'd0);
        en = 1'b1;
        step(3);
        chk("t6_pre_addr", 32'(rom_addr), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_addr", 32'(rom_addr), 32'd0);
        chk("t6_rst_sample", 32'(sample), 32'd0);
        chk("t6_rst_valid", 32'(sample_valid), 32'd0);
        chk("t6_rst_wrap", 32'(wrap), 32'd0);
        en = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(8);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
